// File: rtl/mipi_job_dispatcher.sv
// Job dispatcher between the MIPI receive path and the miner core array.
// Queues jobs in a small FIFO and issues them round-robin to free cores.
//   state   | meaning
//   S_IDLE  | waiting for a queued job, enable and a free core; latches head and target core
//   S_ISSUE | strobes core_start, pops the FIFO, marks the core busy, advances rr pointer
module mipi_job_dispatcher #(
  parameter int NUM_CORES  = 4,
  parameter int DATA_W     = 512,
  parameter int ID_W       = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          rx_pixel_clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             job_data,
  input  logic [ID_W-1:0]               job_id,
  input  logic                          job_valid,
  input  logic                          enable,
  input  logic                          flush,
  input  logic [NUM_CORES-1:0]          core_done,
  output logic [DATA_W-1:0]             core_data,
  output logic [ID_W-1:0]               core_id,
  output logic [NUM_CORES-1:0]          core_start,
  output logic [NUM_CORES-1:0]          cores_idle,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic [15:0]                   drop_count
);

  localparam int CW    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t               state_q, state_d;
  logic                 valid_q;
  logic [DATA_W-1:0]    data_mem_q [FIFO_DEPTH];
  logic [ID_W-1:0]      id_mem_q   [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [15:0]          drop_q, drop_d;
  logic [NUM_CORES-1:0] busy_q, busy_d;
  logic [CW-1:0]        rr_q, rr_d;
  logic [CW-1:0]        sel_q, sel_d;
  logic [NUM_CORES-1:0] core_start_q, core_start_d;
  logic [DATA_W-1:0]    core_data_q, core_data_d;
  logic [ID_W-1:0]      core_id_q, core_id_d;

  logic          job_edge, full, pop, push, drop;
  logic          found;
  logic [CW-1:0] sel_c;

  assign job_edge = job_valid & ~valid_q;
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop      = (state_q == S_ISSUE) && (count_q != '0);
  // A full FIFO still accepts a job when the head leaves in the same cycle.
  assign push     = job_edge & ~flush & (~full | pop);
  assign drop     = job_edge & ~flush & full & ~pop;

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    sel_c = rr_q;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = (int'(rr_q) + k) % NUM_CORES;
      if (!found && !busy_q[idx]) begin
        found = 1'b1;
        sel_c = CW'(idx);
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
    if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    rr_d         = rr_q;
    core_start_d = '0;
    core_data_d  = core_data_q;
    core_id_d    = core_id_q;
    busy_d       = busy_q & ~core_done;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0 && enable && found && !flush) begin
          state_d     = S_ISSUE;
          sel_d       = sel_c;
          core_data_d = data_mem_q[rd_ptr_q];
          core_id_d   = id_mem_q[rd_ptr_q];
        end
      end
      S_ISSUE: begin
        // Setting busy after the done-clear lets a new issue win over a coincident done.
        core_start_d  = NUM_CORES'(1) << sel_q;
        busy_d        = busy_d | (NUM_CORES'(1) << sel_q);
        rr_d          = (sel_q == CW'(NUM_CORES - 1)) ? '0 : sel_q + CW'(1);
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rx_pixel_clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= job_data;
      id_mem_q[wr_ptr_q]   <= job_id;
    end
  end

  always_ff @(posedge rx_pixel_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      valid_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_q       <= '0;
      busy_q       <= '0;
      rr_q         <= '0;
      sel_q        <= '0;
      core_start_q <= '0;
      core_data_q  <= '0;
      core_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= job_valid;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_q       <= drop_d;
      busy_q       <= busy_d;
      rr_q         <= rr_d;
      sel_q        <= sel_d;
      core_start_q <= core_start_d;
      core_data_q  <= core_data_d;
      core_id_q    <= core_id_d;
    end
  end

  assign core_data  = core_data_q;
  assign core_id    = core_id_q;
  assign core_start = core_start_q;
  assign cores_idle = ~busy_q;
  assign fifo_count = count_q;
  assign fifo_full  = full;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_mipi_job_dispatcher.sv
// Scoreboard bench for mipi_job_dispatcher: expected issues are queued as
// jobs are sent and matched whenever the DUT strobes core_start.
module tb_mipi_job_dispatcher;

  logic          clk = 1'b0;
  logic          rst;
  logic [511:0]  job_data;
  logic [15:0]   job_id;
  logic          job_valid;
  logic          enable;
  logic          flush;
  logic [3:0]    core_done;
  logic [511:0]  core_data;
  logic [15:0]   core_id;
  logic [3:0]    core_start;
  logic [3:0]    cores_idle;
  logic [2:0]    fifo_count;
  logic          fifo_full;
  logic [15:0]   drop_count;

  typedef struct {
    logic [3:0]  core;
    logic [15:0] id;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;

  mipi_job_dispatcher dut (
    .rx_pixel_clk (clk),
    .rst          (rst),
    .job_data     (job_data),
    .job_id       (job_id),
    .job_valid    (job_valid),
    .enable       (enable),
    .flush        (flush),
    .core_done    (core_done),
    .core_data    (core_data),
    .core_id      (core_id),
    .core_start   (core_start),
    .cores_idle   (cores_idle),
    .fifo_count   (fifo_count),
    .fifo_full    (fifo_full),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_start(input int core_idx, input logic [15:0] id);
    exp_t x;
    x.core = 4'b0001 << core_idx;
    x.id   = id;
    exp_q.push_back(x);
  endtask

  task automatic send_job(input logic [15:0] id);
    @(negedge clk);
    job_id    = id;
    job_data  = {32{id}};
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic pulse_done(input logic [3:0] m);
    @(negedge clk);
    core_done = m;
    @(negedge clk);
    core_done = 4'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    job_valid = 1'b0;
    flush     = 1'b0;
    core_done = 4'b0;
    enable    = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every start strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && core_start != 4'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_start", {508'b0, core_start}, 512'b0);
      end else begin
        e = exp_q.pop_front();
        chk("start_core", {508'b0, core_start}, {508'b0, e.core});
        chk("start_id",   {496'b0, core_id},    {496'b0, e.id});
        chk("start_data", core_data, {32{e.id}});
      end
    end
  end

  initial begin
    rst = 1'b1; job_data = '0; job_id = '0; job_valid = 1'b0;
    enable = 1'b1; flush = 1'b0; core_done = 4'b0;
    repeat (3) @(negedge clk);
    chk("rst_start",  {508'b0, core_start}, 512'd0);
    chk("rst_idle",   {508'b0, cores_idle}, 512'hF);
    chk("rst_count",  {509'b0, fifo_count}, 512'd0);
    chk("rst_full",   {511'b0, fifo_full},  512'd0);
    chk("rst_drop",   {496'b0, drop_count}, 512'd0);
    chk("rst_id",     {496'b0, core_id},    512'd0);
    chk("rst_data",   core_data,            512'd0);
    rst = 1'b0;

    // single job latency: edge sampled at T, start strobe T+2..T+3
    expect_start(0, 16'h0001);
    @(negedge clk);
    job_id = 16'h0001; job_data = {32{16'h0001}}; job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    chk("lat_n1", {508'b0, core_start}, 512'd0);
    @(negedge clk);
    chk("lat_n2", {508'b0, core_start}, 512'd0);
    @(negedge clk);
    chk("lat_n3", {508'b0, core_start}, 512'h1);
    chk("lat_id", {496'b0, core_id}, 512'h1);
    wait_cyc(2);
    chk("single_idle", {508'b0, cores_idle}, 512'hE);
    chk("single_q", exp_q.size(), 0);

    // round robin across all cores, fifth job waits
    do_reset();
    for (int i = 0; i < 4; i++) expect_start(i, 16'(10 + i));
    expect_start(2, 16'd14);
    for (int i = 0; i < 5; i++) send_job(16'(10 + i));
    wait_cyc(6);
    chk("rr_idle",  {508'b0, cores_idle}, 512'h0);
    chk("rr_count", {509'b0, fifo_count}, 512'd1);
    chk("rr_q4",    exp_q.size(), 1);
    pulse_done(4'b0100);
    wait_cyc(5);
    chk("done2_q",     exp_q.size(), 0);
    chk("done2_count", {509'b0, fifo_count}, 512'd0);
    expect_start(0, 16'd15);
    send_job(16'd15);
    wait_cyc(4);
    chk("wait_count", {509'b0, fifo_count}, 512'd1);
    pulse_done(4'b0001);
    wait_cyc(5);
    chk("done0_q", exp_q.size(), 0);

    // overflow with dispatch held, then drain in order
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) expect_start(i, 16'(20 + i));
    for (int i = 0; i < 6; i++) send_job(16'(20 + i));
    wait_cyc(2);
    chk("ovf_full",  {511'b0, fifo_full},  512'd1);
    chk("ovf_drop",  {496'b0, drop_count}, 512'd2);
    chk("ovf_count", {509'b0, fifo_count}, 512'd4);
    enable = 1'b1;
    wait_cyc(12);
    chk("drain_q",     exp_q.size(), 0);
    chk("drain_count", {509'b0, fifo_count}, 512'd0);
    chk("drain_full",  {511'b0, fifo_full},  512'd0);

    // held job_valid counts once; flush empties the queue
    do_reset();
    expect_start(0, 16'd30);
    @(negedge clk);
    job_id = 16'd30; job_data = {32{16'd30}}; job_valid = 1'b1;
    wait_cyc(100);
    job_valid = 1'b0;
    wait_cyc(4);
    chk("hold_q",     exp_q.size(), 0);
    chk("hold_count", {509'b0, fifo_count}, 512'd0);
    chk("hold_idle",  {508'b0, cores_idle}, 512'hE);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) send_job(16'(31 + i));
    wait_cyc(2);
    chk("pre_flush", {509'b0, fifo_count}, 512'd3);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_count", {509'b0, fifo_count}, 512'd0);
    chk("flush_drop",  {496'b0, drop_count}, 512'd0);
    enable = 1'b1;
    wait_cyc(10);
    chk("flush_idle", {508'b0, cores_idle}, 512'hE);

    // reset while an issue is in flight
    do_reset();
    expect_start(0, 16'd40);
    send_job(16'd40);
    wait_cyc(4);
    chk("pre_rst_idle", {508'b0, cores_idle}, 512'hE);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) send_job(16'(41 + i));
    wait_cyc(2);
    chk("pre_rst_drop", {496'b0, drop_count}, 512'd1);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_start", {508'b0, core_start}, 512'd0);
    chk("mid_rst_idle",  {508'b0, cores_idle}, 512'hF);
    chk("mid_rst_count", {509'b0, fifo_count}, 512'd0);
    chk("mid_rst_drop",  {496'b0, drop_count}, 512'd0);
    chk("mid_rst_full",  {511'b0, fifo_full},  512'd0);
    exp_q.delete();
    rst = 1'b0;
    wait_cyc(6);
    chk("post_rst_idle", {508'b0, cores_idle}, 512'hF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
